pc_unit: RTL and testbench

- Parametrised program-counter unit for the single-cycle CPU.
- Holds the PC register and computes the next PC internally: sequential, branch, jump or register target.
- Adds a stall input, a sticky halt state, and a misaligned-target trap with an exception-PC register.
- Sits between the CU/datapath and instruction memory. Output `pc` drives the instruction-memory address.

---
 rtl/pc_unit.sv | 167 ++++++++++++++++
 tb/tb_pc_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit -- program-counter unit for the single-cycle CPU.
//
// Holds the PC register and selects the next PC from four sources: sequential,
// PC-relative branch, pseudo-absolute jump and register target. It also provides
// a stall input, a sticky HALTED state that only reset leaves, and a trap on a
// misaligned register target. The trap redirects to TRAP_VECTOR and records the
// faulting PC in epc.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   reset       synchronous, active-high reset
//   PCWre       PC write enable (0 = stall)
//   PCSrc       next-PC select: 00 seq, 01 branch, 10 jump, 11 register
//   imm         signed branch offset, in instructions
//   jumpTarget  jump target field, in instructions
//   regTarget   register-sourced target, in bytes
//   halt        halt request
//   pc          current PC (registered), drives the instruction-memory address
//   pcPlus      pc + INSTR_BYTES (combinational)
//   epc         PC of the instruction that caused the last trap (registered)
//   trap        one-cycle trap pulse (registered)
//   halted      high while in the HALTED state (registered)

module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int               INSTR_BYTES  = 4,
  parameter int               IMM_W        = 16,
  parameter int               JT_W         = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic [IMM_W-1:0] imm,
  input  logic [JT_W-1:0]  jumpTarget,
  input  logic [WIDTH-1:0] regTarget,
  input  logic             halt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcPlus,
  output logic [WIDTH-1:0] epc,
  output logic             trap,
  output logic             halted
);

  localparam int ALIGN = $clog2(INSTR_BYTES);

  // Low address bits that must be zero for an aligned target. A mask rather
  // than a part-select keeps ALIGN = 0 legal (mask is then all zeros).
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);

  // Bits of pcPlus that survive into a jump target (the region above the
  // jump field and its alignment bits).
  localparam logic [WIDTH-1:0] JUMP_HI_MASK =
    ~((WIDTH'(1) << (JT_W + ALIGN)) - WIDTH'(1));

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'b00,
    SRC_BRANCH = 2'b01,
    SRC_JUMP   = 2'b10,
    SRC_REG    = 2'b11
  } src_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pc_q, pc_next;
  logic [WIDTH-1:0] epc_q, epc_next;
  logic             trap_q, trap_next;

  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] branch_offset;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] candidate;
  logic             misaligned;

  // ---------------------------------------------------------------------------
  // Next-PC candidates (all arithmetic wraps modulo 2^WIDTH)
  // ---------------------------------------------------------------------------
  assign pc_plus       = pc_q + WIDTH'(INSTR_BYTES);
  assign branch_offset = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} << ALIGN;
  assign branch_target = pc_plus + branch_offset;
  assign jump_target   = (pc_plus & JUMP_HI_MASK) | (WIDTH'(jumpTarget) << ALIGN);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    candidate = pc_plus;
    unique case (src_t'(PCSrc))
      SRC_SEQ:    candidate = pc_plus;
      SRC_BRANCH: candidate = branch_target;
      SRC_JUMP:   candidate = jump_target;
      SRC_REG:    candidate = regTarget;
    endcase
  end

  // Branch and jump targets are aligned by construction; only a register
  // target can carry nonzero low bits.
  assign misaligned = (candidate & ALIGN_MASK) != '0;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register (synchronous reset beats everything)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      pc_q   <= RESET_VECTOR;
      epc_q  <= '0;
      trap_q <= 1'b0;
    end else begin
      state  <= state_next;
      pc_q   <= pc_next;
      epc_q  <= epc_next;
      trap_q <= trap_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // Priority below reset: HALTED hold, stall, halt, misaligned trap, update.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    epc_next   = epc_q;
    trap_next  = 1'b0;
    unique case (state)
      HALTED: begin
        // Sticky: hold everything until reset.
      end
      RUN: begin
        // A stall (PCWre=0) holds pc/epc and ignores halt and PCSrc.
        if (PCWre) begin
          if (halt) begin
            // Halt wins over a misaligned target in the same cycle.
            state_next = HALTED;
          end else if (misaligned) begin
            pc_next   = TRAP_VECTOR;
            epc_next  = pc_q;
            trap_next = 1'b1;
          end else begin
            pc_next = candidate;
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs (all derived from registers except pcPlus)
  // ---------------------------------------------------------------------------
  always_comb begin
    pc     = pc_q;
    pcPlus = pc_plus;
    epc    = epc_q;
    trap   = trap_q;
    halted = (state == HALTED);
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- self-checking bench for pc_unit (default parameters).
// Each step drives one cycle of inputs on the falling edge, pushes the expected
// post-edge outputs into a scoreboard queue, and pops/compares them 1 ns after
// the following rising edge.

module tb_pc_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         PCWre;
  logic [1:0]   PCSrc;
  logic [15:0]  imm;
  logic [25:0]  jumpTarget;
  logic [W-1:0] regTarget;
  logic         halt;
  logic [W-1:0] pc;
  logic [W-1:0] pcPlus;
  logic [W-1:0] epc;
  logic         trap;
  logic         halted;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .PCWre      (PCWre),
    .PCSrc      (PCSrc),
    .imm        (imm),
    .jumpTarget (jumpTarget),
    .regTarget  (regTarget),
    .halt       (halt),
    .pc         (pc),
    .pcPlus     (pcPlus),
    .epc        (epc),
    .trap       (trap),
    .halted     (halted)
  );

  typedef struct {
    logic         rst;
    logic         we;
    logic [1:0]   src;
    logic [15:0]  imm;
    logic [25:0]  jt;
    logic [W-1:0] rt;
    logic         hlt;
    logic [W-1:0] exp_pc;
    logic [W-1:0] exp_epc;
    logic         exp_trap;
    logic         exp_halted;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] pc;
    logic [W-1:0] epc;
    logic         trap;
    logic         halted;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [W-1:0] actual,
                       input logic [W-1:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle, queue the expectation, then compare after the edge.
  task automatic step(input string name, input vec_t v);
    exp_t e;
    @(negedge clk);
    reset      = v.rst;
    PCWre      = v.we;
    PCSrc      = v.src;
    imm        = v.imm;
    jumpTarget = v.jt;
    regTarget  = v.rt;
    halt       = v.hlt;
    sb.push_back('{name, v.exp_pc, v.exp_epc, v.exp_trap, v.exp_halted});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({e.name, ".pc"},     pc,           e.pc);
      check({e.name, ".pcPlus"}, pcPlus,       e.pc + 32'd4);
      check({e.name, ".epc"},    epc,          e.epc);
      check({e.name, ".trap"},   W'(trap),     W'(e.trap));
      check({e.name, ".halted"}, W'(halted),   W'(e.halted));
    end
  endtask

  // Shorthand constructor for a vector record.
  function automatic vec_t mk(input logic rst, input logic we, input logic [1:0] src,
                              input logic [15:0] im, input logic [25:0] jt,
                              input logic [W-1:0] rt, input logic hlt,
                              input logic [W-1:0] xpc, input logic [W-1:0] xepc,
                              input logic xtrap, input logic xhalted);
    vec_t v;
    v.rst = rst; v.we = we; v.src = src; v.imm = im; v.jt = jt; v.rt = rt; v.hlt = hlt;
    v.exp_pc = xpc; v.exp_epc = xepc; v.exp_trap = xtrap; v.exp_halted = xhalted;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    reset = 1'b1; PCWre = 1'b0; PCSrc = 2'b00; imm = '0;
    jumpTarget = '0; regTarget = '0; halt = 1'b0;

    //          rst  we  src    imm       jt          rt             hlt   pc             epc          trap halted
    vecs.push_back(mk(1, 0, 2'b00, 16'h0,    26'h0,      32'h0,         0, 32'h0000_0000, 32'h0,       0, 0)); // reset
    vecs.push_back(mk(0, 1, 2'b00, 16'h0,    26'h0,      32'h0,         0, 32'h0000_0004, 32'h0,       0, 0)); // seq
    vecs.push_back(mk(0, 1, 2'b00, 16'h0,    26'h0,      32'h0,         0, 32'h0000_0008, 32'h0,       0, 0));
    vecs.push_back(mk(0, 1, 2'b00, 16'h0,    26'h0,      32'h0,         0, 32'h0000_000C, 32'h0,       0, 0)); // pcPlus=0x10
    vecs.push_back(mk(0, 1, 2'b11, 16'h0,    26'h0,      32'h0000_0100, 0, 32'h0000_0100, 32'h0,       0, 0)); // jr 0x100
    vecs.push_back(mk(0, 1, 2'b01, 16'hFFFE, 26'h0,      32'h0,         0, 32'h0000_00FC, 32'h0,       0, 0)); // branch -2
    vecs.push_back(mk(0, 1, 2'b11, 16'h0,    26'h0,      32'h1000_0010, 0, 32'h1000_0010, 32'h0,       0, 0));
    vecs.push_back(mk(0, 1, 2'b10, 16'h0,    26'h40,     32'h0,         0, 32'h1000_0100, 32'h0,       0, 0)); // jump
    vecs.push_back(mk(0, 0, 2'b11, 16'h0,    26'h0,      32'h0000_0003, 1, 32'h1000_0100, 32'h0,       0, 0)); // stall+halt
    vecs.push_back(mk(0, 0, 2'b01, 16'h7,    26'h0,      32'h0,         1, 32'h1000_0100, 32'h0,       0, 0));
    vecs.push_back(mk(0, 1, 2'b11, 16'h0,    26'h0,      32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0,       0, 0));
    vecs.push_back(mk(0, 1, 2'b00, 16'h0,    26'h0,      32'h0,         0, 32'h0000_0000, 32'h0,       0, 0)); // wrap
    vecs.push_back(mk(0, 1, 2'b01, 16'h0003, 26'h0,      32'h0,         0, 32'h0000_0010, 32'h0,       0, 0)); // branch +3
    vecs.push_back(mk(0, 1, 2'b11, 16'h0,    26'h0,      32'h0000_0200, 0, 32'h0000_0200, 32'h0,       0, 0));
    vecs.push_back(mk(0, 1, 2'b11, 16'h0,    26'h0,      32'h0000_0302, 0, 32'h0000_0080, 32'h200,     1, 0)); // trap
    vecs.push_back(mk(0, 1, 2'b11, 16'h0,    26'h0,      32'h0000_0300, 0, 32'h0000_0300, 32'h200,     0, 0));

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back traps: trap stays high, epc tracks the faulting pc each cycle.
    step("b2b_trap0", mk(0, 1, 2'b11, 16'h0, 26'h0, 32'h0000_0002, 0, 32'h80, 32'h300, 1, 0));
    step("b2b_trap1", mk(0, 1, 2'b11, 16'h0, 26'h0, 32'h0000_0001, 0, 32'h80, 32'h080, 1, 0));
    step("b2b_stall", mk(0, 0, 2'b11, 16'h0, 26'h0, 32'h0000_0001, 0, 32'h80, 32'h080, 0, 0));
    step("to_0x40",   mk(0, 1, 2'b11, 16'h0, 26'h0, 32'h0000_0040, 0, 32'h40, 32'h080, 0, 0));

    // Halt, held in HALTED while inputs request a move, then reset out.
    step("halt",      mk(0, 1, 2'b00, 16'h0, 26'h0, 32'h0,         1, 32'h40, 32'h080, 0, 1));
    step("halt_hold", mk(0, 1, 2'b11, 16'h0, 26'h0, 32'h0000_0003, 0, 32'h40, 32'h080, 0, 1));
    step("halt_rst",  mk(1, 1, 2'b00, 16'h0, 26'h0, 32'h0,         0, 32'h00, 32'h000, 0, 0));
    step("resume",    mk(0, 1, 2'b00, 16'h0, 26'h0, 32'h0,         0, 32'h04, 32'h000, 0, 0));

    // Simultaneous events: halt beats a misaligned target; reset beats a stall.
    step("sim_to40",  mk(0, 1, 2'b11, 16'h0, 26'h0, 32'h0000_0040, 0, 32'h40, 32'h000, 0, 0));
    step("sim_halt",  mk(0, 1, 2'b11, 16'h0, 26'h0, 32'h0000_0302, 1, 32'h40, 32'h000, 0, 1));
    step("sim_rst",   mk(1, 0, 2'b00, 16'h0, 26'h0, 32'h0,         0, 32'h00, 32'h000, 0, 0));
    step("rst_trap0", mk(0, 1, 2'b11, 16'h0, 26'h0, 32'h0000_0006, 0, 32'h80, 32'h000, 1, 0));
    step("rst_trap1", mk(1, 1, 2'b11, 16'h0, 26'h0, 32'h0000_0006, 0, 32'h00, 32'h000, 0, 0));

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
